// File: rtl/sm_para_3_gen_pkg.sv
// sm_para_3_gen_pkg
// Shared definitions for the sm_para_3_gen control FSM:
//   STATE_W      - width of the state encoding seen on state_o
//   state_t      - state enum (IDLE=0, S1=1, S2=2, ERROR=3)
//   dwell_width  - width of the S1 dwell counter for a given TIMEOUT
// Benches import this package to compare state_o against named states.
package sm_para_3_gen_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE = 2'd0,
    ST_S1   = 2'd1,
    ST_S2   = 2'd2,
    ST_ERR  = 2'd3
  } state_t;

  // The dwell counter must hold values up to TIMEOUT; a disabled timeout
  // still gets a 1-bit counter so the declaration stays legal.
  function automatic int dwell_width(input int timeout);
    int w;
    w = $clog2(timeout + 1);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/sat_cnt.sv
// sat_cnt
// Saturating up-counter with a synchronous clear.
// Ports:
//   clk   - clock, rising edge
//   nrst  - synchronous active-low reset
//   inc   - add one (ignored once the counter is all-ones)
//   clr   - clear to zero; wins over inc
//   cnt   - current count
module sat_cnt #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         nrst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt
);

  localparam logic [W-1:0] CNT_MAX = '1;

  // Clear has priority so a clear landing on the same edge as an
  // increment always leaves the counter at zero.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/sm_para_3_gen.sv
// sm_para_3_gen
// Two-input control FSM (IDLE/S1/S2/ERROR) with an S1 dwell timeout,
// selectable error recovery and a saturating error-entry counter.
// Parameters:
//   TIMEOUT    - consecutive S1 stay cycles allowed before ERROR (0 = off)
//   ERR_STICKY - 1: ERROR exits only on clr_err; 0: also on i1=0,i2=0
//   CNT_W      - width of err_cnt
// Ports:
//   clk, nrst  - clock and synchronous active-low reset
//   i1, i2     - request/qualifier inputs
//   clr_err    - error clear strobe (exits ERROR, clears err_cnt)
//   o1, o2,err - high while in S1, S2, ERROR respectively
//   state_o    - current state encoding
//   err_cnt    - number of ERROR entries, saturating
module sm_para_3_gen
  import sm_para_3_gen_pkg::*;
#(
  parameter int TIMEOUT    = 8,
  parameter bit ERR_STICKY = 1'b1,
  parameter int CNT_W      = 4
) (
  input  logic               clk,
  input  logic               nrst,
  input  logic               i1,
  input  logic               i2,
  input  logic               clr_err,
  output logic               o1,
  output logic               o2,
  output logic               err,
  output logic [STATE_W-1:0] state_o,
  output logic [CNT_W-1:0]   err_cnt
);

  localparam int DW = dwell_width(TIMEOUT);
  localparam logic [DW-1:0] DWELL_LAST = (TIMEOUT == 0) ? '0 : DW'(TIMEOUT - 1);
  localparam logic [DW-1:0] DWELL_MAX  = '1;
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);

  state_t        state;
  state_t        next_state;
  logic [DW-1:0] dwell;
  logic          timeout_hit;
  logic          err_entry;

  // dwell counts completed S1 stay cycles, so the stay cycle seen with
  // dwell == TIMEOUT-1 is the TIMEOUT-th one and must error.
  assign timeout_hit = TIMEOUT_EN && (dwell == DWELL_LAST);
  assign err_entry   = (next_state == ST_ERR) && (state != ST_ERR);
  assign state_o     = state;

  // State register.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state = ST_IDLE;
    case (state)
      ST_IDLE: next_state = i1 ? ST_S1 : ST_IDLE;
      ST_S1: begin
        if (!i1)             next_state = ST_IDLE;
        else if (i2)         next_state = ST_S2;
        else if (timeout_hit) next_state = ST_ERR;
        else                 next_state = ST_S1;
      end
      ST_S2: begin
        if (!i2)      next_state = ST_IDLE;
        else if (!i1) next_state = ST_ERR;
        else          next_state = ST_S2;
      end
      ST_ERR: begin
        if (clr_err)                       next_state = ST_IDLE;
        else if (!ERR_STICKY && !i1 && !i2) next_state = ST_IDLE;
        else                               next_state = ST_ERR;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Outputs are registered from next_state so they move on the same edge
  // as the state register.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      o1  <= 1'b0;
      o2  <= 1'b0;
      err <= 1'b0;
    end else begin
      o1  <= (next_state == ST_S1);
      o2  <= (next_state == ST_S2);
      err <= (next_state == ST_ERR);
    end
  end

  // Dwell only grows while S1 is held; it saturates so that a disabled
  // timeout cannot wrap a narrow counter.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      dwell <= '0;
    end else if ((state == ST_S1) && (next_state == ST_S1)) begin
      if (dwell != DWELL_MAX) begin
        dwell <= dwell + 1'b1;
      end
    end else begin
      dwell <= '0;
    end
  end

  sat_cnt #(
    .W(CNT_W)
  ) u_err_cnt (
    .clk (clk),
    .nrst(nrst),
    .inc (err_entry),
    .clr (clr_err),
    .cnt (err_cnt)
  );

endmodule

// File: tb/tb_sm_para_3_gen.sv
// tb_sm_para_3_gen
// Directed bench for sm_para_3_gen. Three instances share the inputs:
//   dut_a: TIMEOUT=4, sticky errors, CNT_W=4
//   dut_b: TIMEOUT=8, auto-clear errors, CNT_W=2
//   dut_c: TIMEOUT=0 (no timeout), sticky errors, CNT_W=4
module tb_sm_para_3_gen;
  import sm_para_3_gen_pkg::*;

  logic clk;
  logic nrst;
  logic i1;
  logic i2;
  logic clr_err;

  logic       a_o1, a_o2, a_err;
  logic [1:0] a_state;
  logic [3:0] a_cnt;
  logic       b_o1, b_o2, b_err;
  logic [1:0] b_state;
  logic [1:0] b_cnt;
  logic       c_o1, c_o2, c_err;
  logic [1:0] c_state;
  logic [3:0] c_cnt;

  int checks   = 0;
  int failures = 0;

  sm_para_3_gen #(.TIMEOUT(4), .ERR_STICKY(1'b1), .CNT_W(4)) dut_a (
    .clk(clk), .nrst(nrst), .i1(i1), .i2(i2), .clr_err(clr_err),
    .o1(a_o1), .o2(a_o2), .err(a_err), .state_o(a_state), .err_cnt(a_cnt)
  );

  sm_para_3_gen #(.TIMEOUT(8), .ERR_STICKY(1'b0), .CNT_W(2)) dut_b (
    .clk(clk), .nrst(nrst), .i1(i1), .i2(i2), .clr_err(clr_err),
    .o1(b_o1), .o2(b_o2), .err(b_err), .state_o(b_state), .err_cnt(b_cnt)
  );

  sm_para_3_gen #(.TIMEOUT(0), .ERR_STICKY(1'b1), .CNT_W(4)) dut_c (
    .clk(clk), .nrst(nrst), .i1(i1), .i2(i2), .clr_err(clr_err),
    .o1(c_o1), .o2(c_o2), .err(c_err), .state_o(c_state), .err_cnt(c_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge, outputs are sampled at
  // the same point, well away from the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v_i1, input logic v_i2, input logic v_clr);
    i1      = v_i1;
    i2      = v_i2;
    clr_err = v_clr;
  endtask

  task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
    checks++;
    assert (observed === expected)
      else begin
        failures++;
        $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    drive(1'b0, 1'b0, 1'b0);
    tick();
    nrst = 1'b1;
  endtask

  logic [7:0] sat_exp [5];

  initial begin
    nrst = 1'b0;
    drive(1'b1, 1'b0, 1'b0);
    sat_exp = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd3};

    // Reset held with i1 asserted.
    tick();
    tick();
    check("rst_state", {6'd0, a_state}, {6'd0, ST_IDLE});
    check("rst_o1",    {7'd0, a_o1}, 8'd0);
    check("rst_o2",    {7'd0, a_o2}, 8'd0);
    check("rst_err",   {7'd0, a_err}, 8'd0);
    check("rst_cnt",   {4'd0, a_cnt}, 8'd0);
    nrst = 1'b1;
    tick();
    check("rel_o1",    {7'd0, a_o1}, 8'd1);
    check("rel_state", {6'd0, a_state}, {6'd0, ST_S1});

    // S1 -> S2 -> IDLE.
    drive(1'b1, 1'b0, 1'b0);
    tick();
    check("s1_hold", {6'd0, a_state}, {6'd0, ST_S1});
    drive(1'b1, 1'b1, 1'b0);
    tick();
    check("s2_o2",    {7'd0, a_o2}, 8'd1);
    check("s2_o1",    {7'd0, a_o1}, 8'd0);
    check("s2_state", {6'd0, a_state}, {6'd0, ST_S2});
    drive(1'b1, 1'b0, 1'b0);
    tick();
    check("s2_exit_state", {6'd0, a_state}, {6'd0, ST_IDLE});
    check("s2_exit_o2",    {7'd0, a_o2}, 8'd0);
    check("s2_exit_err",   {7'd0, a_err}, 8'd0);

    // Dwell must restart after leaving S1: 2 stays, leave, then 3 stays.
    do_reset();
    drive(1'b1, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    drive(1'b0, 1'b0, 1'b0);
    tick();
    check("dwell_leave", {6'd0, a_state}, {6'd0, ST_IDLE});
    drive(1'b1, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    tick();
    check("dwell_restart", {6'd0, a_state}, {6'd0, ST_S1});

    // Timeout on dut_a: enter S1 then the 4th stay cycle errors.
    do_reset();
    drive(1'b1, 1'b0, 1'b0);
    tick();
    check("to_enter", {6'd0, a_state}, {6'd0, ST_S1});
    tick();
    tick();
    tick();
    check("to_stay3_state", {6'd0, a_state}, {6'd0, ST_S1});
    check("to_stay3_err",   {7'd0, a_err}, 8'd0);
    tick();
    check("to_err",   {7'd0, a_err}, 8'd1);
    check("to_state", {6'd0, a_state}, {6'd0, ST_ERR});
    check("to_cnt",   {4'd0, a_cnt}, 8'd1);
    check("to_o1",    {7'd0, a_o1}, 8'd0);
    drive(1'b0, 1'b0, 1'b0);
    tick();
    check("sticky_hold", {6'd0, a_state}, {6'd0, ST_ERR});
    drive(1'b0, 1'b0, 1'b1);
    tick();
    check("clr_state", {6'd0, a_state}, {6'd0, ST_IDLE});
    check("clr_cnt",   {4'd0, a_cnt}, 8'd0);
    check("clr_err",   {7'd0, a_err}, 8'd0);
    drive(1'b0, 1'b0, 1'b0);

    // S2 with i1 dropped -> ERROR; dut_b auto-clears, dut_a stays.
    do_reset();
    drive(1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b0);
    tick();
    check("b_s2err_state", {6'd0, b_state}, {6'd0, ST_ERR});
    check("b_s2err_err",   {7'd0, b_err}, 8'd1);
    check("b_s2err_cnt",   {6'd0, b_cnt}, 8'd1);
    drive(1'b0, 1'b0, 1'b0);
    tick();
    check("b_auto_state", {6'd0, b_state}, {6'd0, ST_IDLE});
    check("b_auto_err",   {7'd0, b_err}, 8'd0);
    check("b_auto_cnt",   {6'd0, b_cnt}, 8'd1);
    check("a_sticky_state", {6'd0, a_state}, {6'd0, ST_ERR});

    // Saturation of dut_b err_cnt over five entries.
    do_reset();
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 1'b0, 1'b0);
      tick();
      drive(1'b1, 1'b1, 1'b0);
      tick();
      drive(1'b0, 1'b1, 1'b0);
      tick();
      check($sformatf("sat_cnt_%0d", k), {6'd0, b_cnt}, sat_exp[k]);
      drive(1'b0, 1'b0, 1'b0);
      tick();
    end
    // Sixth entry coincides with clr_err.
    drive(1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b0);
    tick();
    drive(1'b0, 1'b1, 1'b1);
    tick();
    check("sat_clr_cnt",   {6'd0, b_cnt}, 8'd0);
    check("sat_clr_err",   {7'd0, b_err}, 8'd1);
    check("sat_clr_state", {6'd0, b_state}, {6'd0, ST_ERR});
    drive(1'b0, 1'b0, 1'b0);

    // Reset mid-S2 on dut_a.
    do_reset();
    drive(1'b1, 1'b0, 1'b0);
    tick();
    drive(1'b1, 1'b1, 1'b0);
    tick();
    check("pre_rst_o2", {7'd0, a_o2}, 8'd1);
    nrst = 1'b0;
    tick();
    check("mid_rst_state", {6'd0, a_state}, {6'd0, ST_IDLE});
    check("mid_rst_o2",    {7'd0, a_o2}, 8'd0);
    check("mid_rst_cnt",   {4'd0, a_cnt}, 8'd0);
    nrst = 1'b1;

    // No timeout on dut_c over 50 S1 stay cycles.
    drive(1'b1, 1'b0, 1'b0);
    tick();
    for (int k = 0; k < 50; k++) begin
      tick();
      check($sformatf("c_hold_%0d", k), {6'd0, c_state}, {6'd0, ST_S1});
    end
    check("c_hold_err", {7'd0, c_err}, 8'd0);
    check("c_hold_cnt", {4'd0, c_cnt}, 8'd0);
    check("c_hold_o1",  {7'd0, c_o1}, 8'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
